// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and saturation limits for the MAC array
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_HIGH = 2'd1,
    DIR_LOW  = 2'd2
  } sticky_e;

  // Limits are returned 64 bits wide; callers slice to the width they compare in.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one accumulator: multiply-saturate, accumulate-saturate, sticky direction
module mac_lane
  import mac_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int INT_BITS  = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 load_i,
  input  logic                 accept_i,
  input  logic [WORD_SIZE-1:0] bias_i,
  input  logic [WORD_SIZE-1:0] mem_i,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic [WORD_SIZE-1:0] acc_o,
  output logic                 sat_o
);

  localparam int FRAC = WORD_SIZE - INT_BITS;
  localparam logic signed [63:0] MAX64 = sat_max(WORD_SIZE);
  localparam logic signed [63:0] MIN64 = sat_min(WORD_SIZE);
  localparam logic signed [2*WORD_SIZE-1:0] PMAX = MAX64[2*WORD_SIZE-1:0];
  localparam logic signed [2*WORD_SIZE-1:0] PMIN = MIN64[2*WORD_SIZE-1:0];
  localparam logic signed [WORD_SIZE:0]     SMAX = MAX64[WORD_SIZE:0];
  localparam logic signed [WORD_SIZE:0]     SMIN = MIN64[WORD_SIZE:0];
  localparam logic [WORD_SIZE-1:0]          WMAX = MAX64[WORD_SIZE-1:0];
  localparam logic [WORD_SIZE-1:0]          WMIN = MIN64[WORD_SIZE-1:0];

  logic [WORD_SIZE-1:0]          acc_q, acc_d;
  sticky_e                       sticky_q, sticky_d;
  logic signed [2*WORD_SIZE-1:0] prod, shifted;
  logic [WORD_SIZE-1:0]          psat;
  logic signed [WORD_SIZE:0]     sum;
  sticky_e                       pdir, sdir, ndir;

  always_comb begin
    prod    = $signed(mem_i) * $signed(data_i);
    shifted = prod >>> FRAC;
    psat    = shifted[WORD_SIZE-1:0];
    pdir    = DIR_NONE;
    if (shifted > PMAX) begin
      psat = WMAX;
      pdir = DIR_HIGH;
    end else if (shifted < PMIN) begin
      psat = WMIN;
      pdir = DIR_LOW;
    end

    sum  = $signed({acc_q[WORD_SIZE-1], acc_q}) + $signed({psat[WORD_SIZE-1], psat});
    sdir = DIR_NONE;
    if (sum > SMAX) begin
      sdir = DIR_HIGH;
    end else if (sum < SMIN) begin
      sdir = DIR_LOW;
    end
    // Sum overflow reflects the value actually stored, so it outranks the product's direction.
    ndir = (sdir != DIR_NONE) ? sdir : pdir;

    acc_d    = acc_q;
    sticky_d = sticky_q;
    if (load_i) begin
      acc_d    = bias_i;
      sticky_d = DIR_NONE;
    end else if (accept_i && (sticky_q == DIR_NONE)) begin
      sticky_d = ndir;
      case (ndir)
        DIR_HIGH: acc_d = WMAX;
        DIR_LOW:  acc_d = WMIN;
        default:  acc_d = sum[WORD_SIZE-1:0];
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_q    <= '0;
      sticky_q <= DIR_NONE;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end

  assign acc_o = acc_q;
  assign sat_o = (sticky_q != DIR_NONE);

endmodule

// File: rtl/saturating_mac_array.sv
// rtl/saturating_mac_array.sv - LANES saturating fixed-point dot-product engines sharing one FSM
module saturating_mac_array
  import mac_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int INT_BITS  = 8,
  parameter int LANES     = 4,
  parameter int N_TERMS   = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       start_i,
  input  logic [LANES*WORD_SIZE-1:0] bias_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [LANES*WORD_SIZE-1:0] mem_i,
  input  logic [WORD_SIZE-1:0]       data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [LANES*WORD_SIZE-1:0] data_o,
  output logic [LANES-1:0]           sat_o,
  output logic                       busy_o
);

  localparam int CW = $clog2(N_TERMS + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load, accept, last_term;

  assign load      = (state_q == ST_IDLE) && start_i;
  assign accept    = (state_q == ST_ACCUM) && valid_i;
  assign last_term = (cnt_q == CW'(N_TERMS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + CW'(1);
          if (last_term) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o = (state_q == ST_ACCUM);
  assign valid_o = (state_q == ST_DONE);
  assign busy_o  = (state_q != ST_IDLE);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mac_lane #(
      .WORD_SIZE(WORD_SIZE),
      .INT_BITS (INT_BITS)
    ) u_lane (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .load_i   (load),
      .accept_i (accept),
      .bias_i   (bias_i[k*WORD_SIZE +: WORD_SIZE]),
      .mem_i    (mem_i[k*WORD_SIZE +: WORD_SIZE]),
      .data_i   (data_i),
      .acc_o    (data_o[k*WORD_SIZE +: WORD_SIZE]),
      .sat_o    (sat_o[k])
    );
  end

endmodule

// File: tb/tb_saturating_mac_array.sv
// tb/tb_saturating_mac_array.sv - scoreboard bench for saturating_mac_array (2 lanes, 2 terms)
module tb_saturating_mac_array;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        start_i;
  logic [31:0] bias_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] mem_i;
  logic [15:0] data_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [1:0]  sat_o;
  logic        busy_o;

  saturating_mac_array #(
    .WORD_SIZE(16),
    .INT_BITS (8),
    .LANES    (2),
    .N_TERMS  (2)
  ) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .start_i  (start_i),
    .bias_i   (bias_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .mem_i    (mem_i),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .sat_o    (sat_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: samples just after the falling edge, when drivers have settled.
  initial begin
    forever begin
      @(negedge clk_i);
      #1;
      if (reset_n_i && valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", {31'd0, valid_o}, 32'd0);
        end else begin
          chk("result_data", data_o, sb[0].d);
          chk("result_sat", {30'd0, sat_o}, {30'd0, sb[0].s});
          if (ready_i) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_term(input logic [31:0] m, input logic [15:0] d, input bit last);
    int n;
    n = 0;
    mem_i   = m;
    data_i  = d;
    valid_i = 1'b1;
    while (!ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) chk("ready_timeout", {31'd0, ready_o}, 32'd1);
    if (last) chk("valid_before_last", {31'd0, valid_o}, 32'd0);
    @(negedge clk_i);
    valid_i = 1'b0;
    if (last) chk("valid_latency", {31'd0, valid_o}, 32'd1);
    else      chk("valid_low_accum", {31'd0, valid_o}, 32'd0);
  endtask

  task automatic run_job(input logic [31:0] bias,
                         input logic [31:0] m0, input logic [15:0] d0,
                         input logic [31:0] m1, input logic [15:0] d1,
                         input int gap, input int stall,
                         input logic [31:0] exp_d, input logic [1:0] exp_s);
    exp_t e;
    e.d = exp_d;
    e.s = exp_s;
    sb.push_back(e);
    start_i = 1'b1;
    bias_i  = bias;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("busy_in_accum", {31'd0, busy_o}, 32'd1);
    chk("bias_loaded", data_o, bias);
    send_term(m0, d0, 1'b0);
    repeat (gap) @(negedge clk_i);
    send_term(m1, d1, 1'b1);
    if (stall > 0) begin
      ready_i = 1'b0;
      for (int i = 0; i < stall; i++) begin
        start_i = (i == 2);
        @(negedge clk_i);
      end
      start_i = 1'b0;
      chk("stall_still_done", {31'd0, valid_o}, 32'd1);
    end
    ready_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("idle_after_accept", {31'd0, busy_o}, 32'd0);
    chk("valid_low_idle", {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    reset_n_i = 1'b0;
    start_i   = 1'b0;
    bias_i    = '0;
    valid_i   = 1'b0;
    mem_i     = '0;
    data_i    = '0;
    ready_i   = 1'b1;
    #1;
    chk("reset_data", data_o, 32'd0);
    chk("reset_flags", {27'd0, sat_o, ready_o, valid_o, busy_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    // Basic: 1.0 + 2.0*1.5 + 2.0*1.5 = 7.0 in both lanes
    run_job(32'h0100_0100, 32'h0200_0200, 16'h0180, 32'h0200_0200, 16'h0180, 0, 0,
            32'h0700_0700, 2'b00);
    // Negative: -1.0*0.5 then a zero weight
    run_job(32'h0000_0000, 32'hFF00_FF00, 16'h0080, 32'h0000_0000, 16'h1234, 0, 0,
            32'hFF80_FF80, 2'b00);
    // Lane0 saturates high and stays there; lane1 lands exactly on max without saturating
    run_job(32'h0000_7000, 32'h0100_7FFF, 16'h7FFF, 32'h0000_8000, 16'h7FFF, 0, 0,
            32'h7FFF_7FFF, 2'b01);
    // Lane0 sum saturates low then holds min; lane1 exercises floor rounding of negatives
    run_job(32'h0000_8100, 32'hFFFF_8000, 16'h0100, 32'hFFFF_7FFF, 16'h7FFF, 0, 0,
            32'hFF7F_8000, 2'b01);
    // Backpressure with ignored start, plus input gaps
    run_job(32'h0100_0100, 32'h0200_0200, 16'h0180, 32'h0200_0200, 16'h0180, 3, 5,
            32'h0700_0700, 2'b00);

    // Reset mid-ACCUM after one term
    start_i = 1'b1;
    bias_i  = 32'h0100_0100;
    @(negedge clk_i);
    start_i = 1'b0;
    send_term(32'h0200_0200, 16'h0180, 1'b0);
    chk("live_acc_mid_job", data_o, 32'h0400_0400);
    #3;
    reset_n_i = 1'b0;
    #1;
    chk("async_reset_data", data_o, 32'd0);
    chk("async_reset_flags", {27'd0, sat_o, ready_o, valid_o, busy_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    run_job(32'h0100_0100, 32'h0200_0200, 16'h0180, 32'h0200_0200, 16'h0180, 0, 0,
            32'h0700_0700, 2'b00);

    repeat (3) @(negedge clk_i);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
